// File: rtl/param_lifo_stack.sv
// Parameterised LIFO stack with registered pop data and replace-top on simultaneous push+pop.
// Define STACK_ERR_FLAG_EN to compile in sticky overflow/underflow flags; otherwise they read 0.
module param_lifo_stack #(
    parameter int  DATA_W   = 4,
    parameter int  DEPTH    = 16,
    parameter int  AF_LEVEL = DEPTH - 2,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              stack_reset,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              mux_sel,
    input  logic [DATA_W-1:0] data_1_in,
    input  logic [DATA_W-1:0] data_2_in,
    input  logic              err_clr_i,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [DATA_W-1:0] wr_data;
    logic [IDX_W-1:0]  top_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic              full;
    logic              empty;
    logic              wr_en;
    logic              rd_en;
    logic              ovf_evt;
    logic              udf_evt;

    assign full          = (count_q == CNT_W'(DEPTH));
    assign empty         = (count_q == '0);
    assign full_o        = full;
    assign empty_o       = empty;
    assign almost_full_o = (count_q >= CNT_W'(AF_LEVEL));
    assign count_o       = count_q;
    assign wr_data       = mux_sel ? data_1_in : data_2_in;
    // Only meaningful when count_q > 0; low bits wrap correctly because count-1 < DEPTH.
    assign top_idx       = count_q[IDX_W-1:0] - IDX_W'(1);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        rd_en   = pop_i && !empty;
        wr_en   = push_i && (!full || pop_i);
        wr_idx  = rd_en ? top_idx : count_q[IDX_W-1:0];
        ovf_evt = push_i && !pop_i && full;
        udf_evt = pop_i && empty;
        count_d = count_q;
        if (wr_en && !rd_en) begin
            count_d = count_q + CNT_W'(1);
        end else if (rd_en && !push_i) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (stack_reset) begin
            count_q      <= '0;
            data_out     <= '0;
            data_valid_o <= 1'b0;
        end else begin
            count_q      <= count_d;
            data_valid_o <= rd_en;
            if (rd_en) begin
                data_out <= mem[top_idx];
            end
        end
    end

    // NOTE: storage is deliberately not reset; count_q alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (!stack_reset && wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

`ifdef STACK_ERR_FLAG_EN
    logic overflow_q;
    logic underflow_q;

    // An event in the same cycle as err_clr_i keeps the flag set.
    always_ff @(posedge clk) begin
        if (stack_reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (ovf_evt) begin
                overflow_q <= 1'b1;
            end else if (err_clr_i) begin
                overflow_q <= 1'b0;
            end
            if (udf_evt) begin
                underflow_q <= 1'b1;
            end else if (err_clr_i) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
`else
    logic unused_err;
    assign unused_err  = ^{err_clr_i, ovf_evt, udf_evt};
    assign overflow_o  = 1'b0;
    assign underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_param_lifo_stack.sv
// Directed self-checking bench for param_lifo_stack (DATA_W=8, DEPTH=4, AF_LEVEL=3).
// Flag expectations follow STACK_ERR_FLAG_EN, which is shared with the design build.
module tb_param_lifo_stack;

`ifdef STACK_ERR_FLAG_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] count;
        logic       full;
        logic       empty;
        logic       af;
        logic       dv;
        logic [7:0] dout;
        logic       ovf;
        logic       udf;
    } obs_t;

    logic       clk = 1'b0;
    logic       stack_reset = 1'b0;
    logic       push_i = 1'b0;
    logic       pop_i = 1'b0;
    logic       mux_sel = 1'b1;
    logic [7:0] data_1_in = '0;
    logic [7:0] data_2_in = '0;
    logic       err_clr_i = 1'b0;
    logic [7:0] data_out;
    logic       data_valid_o;
    logic [2:0] count_o;
    logic       full_o;
    logic       empty_o;
    logic       almost_full_o;
    logic       overflow_o;
    logic       underflow_o;

    int checks = 0;
    int errors = 0;

    param_lifo_stack #(.DATA_W(8), .DEPTH(4), .AF_LEVEL(3)) dut (
        .clk          (clk),
        .stack_reset  (stack_reset),
        .push_i       (push_i),
        .pop_i        (pop_i),
        .mux_sel      (mux_sel),
        .data_1_in    (data_1_in),
        .data_2_in    (data_2_in),
        .err_clr_i    (err_clr_i),
        .data_out     (data_out),
        .data_valid_o (data_valid_o),
        .count_o      (count_o),
        .full_o       (full_o),
        .empty_o      (empty_o),
        .almost_full_o(almost_full_o),
        .overflow_o   (overflow_o),
        .underflow_o  (underflow_o)
    );

    always #5 clk = ~clk;

    function automatic obs_t observe();
        return '{count_o, full_o, empty_o, almost_full_o, data_valid_o, data_out, overflow_o, underflow_o};
    endfunction

    function automatic obs_t mk(input int cnt, input bit f, input bit e, input bit af, input bit dv,
                                input logic [7:0] d, input bit ovf, input bit udf);
        return '{cnt[2:0], f, e, af, dv, d, ovf, udf};
    endfunction

    // Drive one cycle of inputs, then sample 1ns after the rising edge.
    task automatic cyc(input bit rst, input bit push, input bit pop, input bit sel,
                       input logic [7:0] d1, input logic [7:0] d2, input bit clr);
        stack_reset = rst;
        push_i      = push;
        pop_i       = pop;
        mux_sel     = sel;
        data_1_in   = d1;
        data_2_in   = d2;
        err_clr_i   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, d, 8'h00, 1'b0);
    endtask

    task automatic pop();
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic clr();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1);
    endtask

    task automatic test_reset();
        obs_t got;
        obs_t exp;
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'hEE, 8'h00, 1'b0);
        got = observe();
        exp = mk(0, 0, 1, 0, 0, 8'h00, 0, 0);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_state got %p required %p", got, exp);
        end
        idle();
        got = observe();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_idle got %p required %p", got, exp);
        end
    endtask

    task automatic test_push_pop_order();
        logic [7:0] d [4];
        obs_t got;
        obs_t exp;
        d = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            push(d[i]);
            got = observe();
            exp = mk(i + 1, i == 3, 0, (i + 1) >= 3, 0, 8'h00, 0, 0);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL push_%0d got %p required %p", i, got, exp);
            end
        end
        for (int i = 0; i < 4; i++) begin
            pop();
            got = observe();
            exp = mk(3 - i, 0, i == 3, (3 - i) >= 3, 1, d[3 - i], 0, 0);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL pop_%0d got %p required %p", i, got, exp);
            end
        end
        idle();
        got = observe();
        exp = mk(0, 0, 1, 0, 0, 8'h11, 0, 0);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL pop_hold got %p required %p", got, exp);
        end
    endtask

    task automatic test_overflow();
        obs_t got;
        obs_t exp [6];
        string tag [6];
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        exp[0] = mk(4, 1, 0, 1, 0, 8'h11, 0, 0);      tag[0] = "ovf_full";
        exp[1] = mk(4, 1, 0, 1, 0, 8'h11, ERR_EN, 0); tag[1] = "ovf_push";
        exp[2] = mk(4, 1, 0, 1, 0, 8'h11, ERR_EN, 0); tag[2] = "ovf_sticky";
        exp[3] = mk(3, 0, 0, 1, 1, 8'h44, ERR_EN, 0); tag[3] = "ovf_storage";
        exp[4] = mk(3, 0, 0, 1, 0, 8'h44, 0, 0);      tag[4] = "ovf_clear";
        exp[5] = mk(4, 1, 0, 1, 0, 8'h44, ERR_EN, 0); tag[5] = "ovf_set_wins";
        for (int i = 0; i < 6; i++) begin
            case (i)
                1: push(8'h55);
                2: idle();
                3: pop();
                4: clr();
                5: begin
                    push(8'h44);
                    cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h55, 8'h00, 1'b1);
                end
                default: ;
            endcase
            got = observe();
            checks++;
            if (got !== exp[i]) begin
                errors++;
                $display("FAIL %s got %p required %p", tag[i], got, exp[i]);
            end
        end
        clr();
    endtask

    task automatic test_underflow();
        obs_t got;
        obs_t exp [5];
        string tag [5];
        for (int i = 0; i < 4; i++) pop();
        exp[0] = mk(0, 0, 1, 0, 0, 8'h11, 0, ERR_EN); tag[0] = "udf_pop";
        exp[1] = mk(0, 0, 1, 0, 0, 8'h11, 0, ERR_EN); tag[1] = "udf_sticky";
        exp[2] = mk(0, 0, 1, 0, 0, 8'h11, 0, 0);      tag[2] = "udf_clear";
        exp[3] = mk(1, 0, 0, 0, 0, 8'h11, 0, ERR_EN); tag[3] = "udf_push_pop_empty";
        exp[4] = mk(0, 0, 1, 0, 1, 8'hAA, 0, 0);      tag[4] = "udf_pop_aa";
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: pop();
                1: idle();
                2: clr();
                3: cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'hAA, 8'h00, 1'b0);
                default: begin
                    clr();
                    pop();
                end
            endcase
            got = observe();
            checks++;
            if (got !== exp[i]) begin
                errors++;
                $display("FAIL %s got %p required %p", tag[i], got, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back_replace();
        obs_t got;
        obs_t exp [5];
        string tag [5];
        push(8'h11);
        push(8'h22);
        exp[0] = mk(2, 0, 0, 0, 1, 8'h22, 0, 0); tag[0] = "rep_alt_src";
        exp[1] = mk(1, 0, 0, 0, 1, 8'h99, 0, 0); tag[1] = "rep_pop_new_top";
        exp[2] = mk(0, 0, 1, 0, 1, 8'h11, 0, 0); tag[2] = "rep_pop_bottom";
        exp[3] = mk(4, 1, 0, 1, 1, 8'h44, 0, 0); tag[3] = "rep_full";
        exp[4] = mk(3, 0, 0, 1, 1, 8'h66, 0, 0); tag[4] = "rep_full_pop";
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h77, 8'h99, 1'b0);
                1, 2, 4: pop();
                default: begin
                    push(8'h11);
                    push(8'h22);
                    push(8'h33);
                    push(8'h44);
                    cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h66, 8'h88, 1'b0);
                end
            endcase
            got = observe();
            checks++;
            if (got !== exp[i]) begin
                errors++;
                $display("FAIL %s got %p required %p", tag[i], got, exp[i]);
            end
        end
    endtask

    task automatic test_reset_midop();
        obs_t got;
        obs_t exp [3];
        string tag [3];
        exp[0] = mk(3, 0, 0, 1, 1, 8'h5A, ERR_EN, 0); tag[0] = "mid_flag_setup";
        exp[1] = mk(0, 0, 1, 0, 0, 8'h00, 0, 0);      tag[1] = "mid_reset";
        exp[2] = mk(0, 0, 1, 0, 0, 8'h00, 0, ERR_EN); tag[2] = "mid_pop_after_reset";
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin
                    push(8'h5A);
                    push(8'hA5);
                    pop();
                end
                1: cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'hC3, 8'h00, 1'b0);
                default: pop();
            endcase
            got = observe();
            checks++;
            if (got !== exp[i]) begin
                errors++;
                $display("FAIL %s got %p required %p", tag[i], got, exp[i]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_push_pop_order();
        test_overflow();
        test_underflow();
        test_back_to_back_replace();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
